// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encoding,
// parity mode codes and the default bit period.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      WAIT_IDLE
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // 27 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 234;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is a
// parameter so idle-high lines (UART) and idle-low lines (buttons) both fit.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, optional parity, one or
// two stop bits, false-start rejection, error flags and a valid/ready output.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int IW   = $clog2(DATA_BITS + 1);

   logic rx_s;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (uart_rx),
      .q   (rx_s)
   );

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 perr_acc_q, perr_acc_d;
   logic                 pend_q, pend_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 bit_tick;

   assign bit_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      ferr_acc_d   = ferr_acc_q;
      perr_acc_d   = perr_acc_q;
      pend_d       = 1'b0;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         // The IDLE detection cycle counts towards the half bit, hence HALF-2.
         START: begin
            if (cnt_q == CW'(HALF - 2)) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DATA;
                  idx_d      = '0;
                  ferr_acc_d = 1'b0;
                  perr_acc_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? PAR : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PAR: begin
            if (bit_tick) begin
               cnt_d      = '0;
               perr_acc_d = ((^shift_q) ^ rx_s) != (PARITY == PAR_ODD);
               state_d    = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_tick) begin
               cnt_d = '0;
               if (!rx_s) begin
                  ferr_acc_d = 1'b1;
               end
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  idx_d   = '0;
                  pend_d  = 1'b1;
                  state_d = (ferr_acc_q || !rx_s) ? WAIT_IDLE : IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // A held-low line (break) must not look like a stream of start bits.
         WAIT_IDLE: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (pend_q) begin
         rx_data_d    = shift_q;
         frame_err_d  = ferr_acc_q;
         parity_err_d = perr_acc_q;
         overrun_d    = rx_valid_q && !rx_ready;
         rx_valid_d   = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         ferr_acc_q   <= 1'b0;
         perr_acc_q   <= 1'b0;
         pend_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         ferr_acc_q   <= ferr_acc_d;
         perr_acc_q   <= perr_acc_d;
         pend_q       <= pend_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 7E1, 8N2) driven
// with ideal serial frames; expected words are queued and a monitor compares.
module tb_uart_rx_param;
   import uart_pkg::*;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   typedef struct packed {
      logic [1:0] inst;
      logic [8:0] data;
      logic       ferr;
      logic       perr;
      logic       ovr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx [3];
   logic ready [3];

   logic [7:0] rd0;
   logic [6:0] rd1;
   logic [7:0] rd2;
   logic [8:0] obs_data [3];
   logic       obs_valid [3];
   logic       obs_ferr [3];
   logic       obs_perr [3];
   logic       obs_ovr [3];

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cycle_cnt = 0;
   int   rise_cycle [3] = '{0, 0, 0};
   bit   outstanding [3] = '{1'b0, 1'b0, 1'b0};
   bit   prev_valid [3] = '{1'b0, 1'b0, 1'b0};
   bit   prev_ready [3] = '{1'b0, 1'b0, 1'b0};
   bit   clear_pending [3] = '{1'b0, 1'b0, 1'b0};
   logic [11:0] prev_bundle [3];

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_8n1 (
      .clk(clk), .rst(rst), .uart_rx(tx[0]), .rx_data(rd0), .rx_valid(obs_valid[0]),
      .rx_ready(ready[0]), .frame_err(obs_ferr[0]), .parity_err(obs_perr[0]), .overrun(obs_ovr[0]));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_7e1 (
      .clk(clk), .rst(rst), .uart_rx(tx[1]), .rx_data(rd1), .rx_valid(obs_valid[1]),
      .rx_ready(ready[1]), .frame_err(obs_ferr[1]), .parity_err(obs_perr[1]), .overrun(obs_ovr[1]));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_8n2 (
      .clk(clk), .rst(rst), .uart_rx(tx[2]), .rx_data(rd2), .rx_valid(obs_valid[2]),
      .rx_ready(ready[2]), .frame_err(obs_ferr[2]), .parity_err(obs_perr[2]), .overrun(obs_ovr[2]));

   assign obs_data[0] = {1'b0, rd0};
   assign obs_data[1] = {2'b00, rd1};
   assign obs_data[2] = {1'b0, rd2};

   function automatic int dbits(input int i);
      return (i == 1) ? 7 : 8;
   endfunction

   function automatic int pmode(input int i);
      return (i == 1) ? PAR_EVEN : PAR_NONE;
   endfunction

   function automatic int sbits(input int i);
      return (i == 2) ? 2 : 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s inst%0d rx_valid", tag, i), 32'(obs_valid[i]), 0);
         checkOutput($sformatf("%s inst%0d rx_data", tag, i), 32'(obs_data[i]), 0);
         checkOutput($sformatf("%s inst%0d frame_err", tag, i), 32'(obs_ferr[i]), 0);
         checkOutput($sformatf("%s inst%0d parity_err", tag, i), 32'(obs_perr[i]), 0);
         checkOutput($sformatf("%s inst%0d overrun", tag, i), 32'(obs_ovr[i]), 0);
      end
   endtask

   // Drive one line level for n whole clock cycles; always leaves us at posedge+1.
   task automatic hold_line(input int inst, input logic v, input int n);
      tx[inst] = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send one frame on receiver 'inst' and queue the word it should produce.
   task automatic applyStimulus(input int inst, input logic [8:0] data, input bit flip_par,
                                input bit [1:0] stop_low, input int hold_low);
      int         db, pm, sb, fall, lat;
      logic [8:0] d;
      logic       ones, pbit;
      exp_t       e;
      db = dbits(inst);
      pm = pmode(inst);
      sb = sbits(inst);
      d  = '0;
      for (int k = 0; k < db; k++) d[k] = data[k];
      ones = ^d;
      pbit = ((pm == PAR_ODD) ? ~ones : ones) ^ flip_par;
      e.inst = 2'(inst);
      e.data = d;
      e.perr = (pm != PAR_NONE) && ((ones ^ pbit) != (pm == PAR_ODD));
      e.ferr = stop_low[0] || (sb == 2 && stop_low[1]);
      e.ovr  = outstanding[inst];
      outstanding[inst] = !ready[inst];
      exp_q.push_back(e);
      lat  = HALF + (db + ((pm != PAR_NONE) ? 1 : 0) + sb) * CPB + 3;
      fall = cycle_cnt;
      hold_line(inst, 1'b0, CPB);
      for (int k = 0; k < db; k++) hold_line(inst, d[k], CPB);
      if (pm != PAR_NONE) hold_line(inst, pbit, CPB);
      for (int k = 0; k < sb; k++) hold_line(inst, !stop_low[k], CPB);
      checkOutput($sformatf("inst%0d latency data %0h", inst, d), 32'(rise_cycle[inst] - fall), 32'(lat));
      if (hold_low > 0) hold_line(inst, 1'b0, hold_low);
      tx[inst] = 1'b1;
   endtask

   // Leave a word pending, abandon a frame mid-data with reset, then re-receive.
   task automatic resetMidFrame(input int inst);
      ready[inst] = 1'b0;
      applyStimulus(inst, 9'h05A, 1'b0, 2'b00, 0);
      hold_line(inst, 1'b1, 10);
      hold_line(inst, 1'b0, CPB);
      hold_line(inst, 1'b1, CPB);
      hold_line(inst, 1'b0, HALF);
      rst = 1'b1;
      #1;
      checkIdleOutputs($sformatf("mid-frame reset inst%0d", inst));
      tx[inst] = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      outstanding[inst] = 1'b0;
      ready[inst] = 1'b1;
      hold_line(inst, 1'b1, 2 * CPB);
      applyStimulus(inst, 9'h07E, 1'b0, 2'b00, 0);
      hold_line(inst, 1'b1, 20);
   endtask

   // Monitor: a new word is a rising rx_valid, a word following an accept, or
   // an overwrite while unaccepted; each one pops the scoreboard.
   always @(negedge clk) begin
      logic [11:0] bundle;
      exp_t        e;
      for (int i = 0; i < 3; i++) begin
         bundle = {obs_data[i], obs_ferr[i], obs_perr[i], obs_ovr[i]};
         if (clear_pending[i]) begin
            checkOutput($sformatf("inst%0d rx_valid clears after accept", i), 32'(obs_valid[i]), 0);
            clear_pending[i] = 1'b0;
         end
         if (!rst && obs_valid[i] &&
             (!prev_valid[i] || prev_ready[i] || bundle != prev_bundle[i])) begin
            rise_cycle[i] = cycle_cnt;
            if (exp_q.size() == 0) begin
               checkOutput($sformatf("inst%0d unexpected word %0h", i, obs_data[i]), 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("inst%0d word source", i), 32'(i), 32'(e.inst));
               checkOutput($sformatf("inst%0d rx_data", i), 32'(obs_data[i]), 32'(e.data));
               checkOutput($sformatf("inst%0d frame_err", i), 32'(obs_ferr[i]), 32'(e.ferr));
               checkOutput($sformatf("inst%0d parity_err", i), 32'(obs_perr[i]), 32'(e.perr));
               checkOutput($sformatf("inst%0d overrun", i), 32'(obs_ovr[i]), 32'(e.ovr));
               if (ready[i]) clear_pending[i] = 1'b1;
            end
         end
         prev_valid[i]  = obs_valid[i];
         prev_ready[i]  = ready[i];
         prev_bundle[i] = bundle;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         sb;
      bit [1:0]   sl;
      logic [8:0] rnd;
      for (int i = 0; i < 3; i++) begin
         tx[i]    = 1'b1;
         ready[i] = 1'b1;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkIdleOutputs("reset");
      rst = 1'b0;
      hold_line(0, 1'b1, 10);

      $display("[TB] 8N1 basic byte 0xA5");
      applyStimulus(0, 9'h0A5, 1'b0, 2'b00, 0);
      hold_line(0, 1'b1, 20);

      $display("[TB] 7E1 parity good then bad");
      applyStimulus(1, 9'h041, 1'b0, 2'b00, 0);
      hold_line(1, 1'b1, 20);
      applyStimulus(1, 9'h041, 1'b1, 2'b00, 0);
      hold_line(1, 1'b1, 20);

      $display("[TB] frame error with break");
      applyStimulus(0, 9'h03C, 1'b0, 2'b01, 40);
      hold_line(0, 1'b1, 30);
      applyStimulus(0, 9'h0C3, 1'b0, 2'b00, 0);
      hold_line(0, 1'b1, 20);

      $display("[TB] false start glitch");
      hold_line(0, 1'b0, 6);
      hold_line(0, 1'b1, 40);
      applyStimulus(0, 9'h055, 1'b0, 2'b00, 0);
      hold_line(0, 1'b1, 20);

      $display("[TB] overrun with rx_ready low");
      ready[0] = 1'b0;
      applyStimulus(0, 9'h011, 1'b0, 2'b00, 0);
      hold_line(0, 1'b1, 10);
      applyStimulus(0, 9'h022, 1'b0, 2'b00, 0);
      hold_line(0, 1'b1, 10);
      ready[0] = 1'b1;
      outstanding[0] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("overrun word accepted", 32'(obs_valid[0]), 0);
      hold_line(0, 1'b1, 20);

      $display("[TB] reset mid-frame, 8N1 and 8N2");
      resetMidFrame(0);
      resetMidFrame(2);

      $display("[TB] randomized frames");
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 6; n++) begin
            sb  = sbits(i);
            rnd = 9'($urandom);
            sl  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, (sb == 2) ? 3 : 1)) : 2'b00;
            applyStimulus(i, rnd, 1'($urandom_range(0, 1)), sl, 0);
            hold_line(i, 1'b1, $urandom_range(2, 24));
         end
      end

      hold_line(0, 1'b1, 40);
      checkOutput("scoreboard drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. It supports configurable data width, optional parity and one or two stop bits. It adds an input synchroniser, a false-start check, error flags and a valid/ready output handshake with overrun detection. It sits between the board RX pin and any byte consumer, such as LED display logic or a command parser.

Parameters:
CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200); legal values are ≥ 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
uart_rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word, LSB = first bit on the wire
rx_valid  output  1  rx_data and the flags below are valid; held until accepted
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready at a clk edge
frame_err  output  1  a stop bit was sampled low; qualified by rx_valid
parity_err  output  1  parity mismatch; always 0 when PARITY = 0; qualified by rx_valid
overrun  output  1  a word was overwritten before it was accepted; qualified by rx_valid

Behaviour:
- Reset (asynchronous, active-high):
  - The synchroniser flops are set to 1.
  - The state machine goes to IDLE.
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0.
  - Counters are cleared.
  - Reset mid-frame abandons the frame; no partial word is ever presented.
- Synchroniser: uart_rx passes through 2 flops to give rx_s. All timing below is relative to rx_s.
- HALF = CLKS_PER_BIT/2 (integer division). The bit counter is $clog2(CLKS_PER_BIT) bits wide. The index counter is $clog2(DATA_BITS+1) bits wide.
- States:
  - IDLE: when rx_s = 0, clear the counter and go to START.
  - START: count HALF-1 further cycles so that the sample falls at mid start bit.
    - rx_s = 1 there: false start, go to IDLE, no output.
    - rx_s = 0 there: clear the counter and go to DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles and shift it in LSB first. After DATA_BITS samples, go to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR: one sample. parity_ok is true when (XOR of data ^ sample) equals 1 for odd or 0 for even.
  - STOP: sample STOP_BITS times at CLKS_PER_BIT spacing. Any low sample marks a frame error. After the final sample, deliver the word.
    - No frame error: go to IDLE.
    - Frame error: go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- Delivery: happens on the clock edge after the last stop-bit sample.
  - rx_data, frame_err, parity_err and rx_valid = 1 are all loaded together.
  - A frame with a frame error or parity error is still delivered, with its flag set.
- Handshake:
  - rx_valid falls on the edge where rx_ready = 1, unless a delivery occurs on the same edge.
  - Delivery and acceptance on the same edge: the old word is consumed and the new word is loaded. rx_valid stays 1 and overrun = 0.
  - Delivery while rx_valid = 1 and rx_ready = 0: the new word overwrites the old one and overrun = 1 for the new word.
  - rx_ready is ignored while rx_valid = 0.
- Reception never stalls: the receiver keeps sampling regardless of rx_ready.
- Latency: from the rx_s falling edge to rx_valid is HALF + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if PARITY ≠ 0, else 0. Add 2 cycles when measuring from the pin.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PAR, STOP, WAIT_IDLE);
  - the PARITY codes (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2);
  - the default CLKS_PER_BIT of 234.
- One natural sub-module, sync_2ff: a 2-flop synchroniser with a reset value parameter, here set to 1. It is reusable for the button inputs.
- Everything else lives in a single module.

Test Plan:
CLKS_PER_BIT = 16 for all benches. The bench drives uart_rx with ideal bit timing and holds rx_ready = 1 unless a scenario says otherwise.
1. 8N1, byte 0xA5 → rx_valid rises 16·9 + 8 + 3 cycles after the pin falls, with rx_data = 0xA5 and all flags 0. rx_valid clears on the next edge.
2. PARITY = 2, DATA_BITS = 7, 0x41 sent once with parity bit 0 and once with 1 → the first word has parity_err = 0 and the second has parity_err = 1. Both words are 0x41.
3. 0x3C with the stop bit forced low, then the line held low for 40 cycles → frame_err = 1 with rx_data = 0x3C. No further rx_valid appears until the line is high and a new start bit arrives.
4. 6-cycle low glitch on an idle line → no rx_valid. A following 0x55 is received correctly.
5. rx_ready = 0 while 0x11 and then 0x22 are sent → the second delivery shows rx_data = 0x22 with overrun = 1. Raising rx_ready clears rx_valid.
6. rst asserted mid-byte during DATA, then a full 0x7E frame → all outputs are 0 during reset, no spurious word appears, and 0x7E is delivered with all flags 0. Repeat the run with STOP_BITS = 2.
